// File: rtl/clksw_pkg.sv
// clksw_pkg: shared state encoding, counter widths and phase helper for the clock-switch scheduler
package clksw_pkg;
  typedef enum logic [1:0] {
    LS_RUN  = 2'd0,
    LS_STOP = 2'd1,
    HS_RUN  = 2'd2,
    HS_STOP = 2'd3
  } state_t;
  localparam int DIV_W  = 2;
  localparam int PH_W   = 3;
  localparam int DEAD_W = 4;
  function automatic logic [PH_W-1:0] phase_last(input logic [DIV_W-1:0] div);
    return PH_W'((1 << div) - 1);
  endfunction
endpackage

// File: rtl/clksw_sync.sv
// clksw_sync: multi-flop synchroniser for the BBC clock with rise/fall detection on hsclk
module clksw_sync #(
  parameter int STAGES = 2
) (
  input  logic hsclk,
  input  logic resetb,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_p;
  // shift the async input through the chain and keep one delayed copy for edge detect
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_sync <= '0;
      r_p    <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_p    <= r_sync[STAGES-1];
    end
  end
  assign o_s    = r_sync[STAGES-1];
  assign o_rise = o_s & ~r_p;
  assign o_fall = ~o_s & r_p;
endmodule

// File: rtl/clksw_sched.sv
// clksw_sched: glitch-free CPU clock switch between divided hsclk and the resynchronised BBC clock
module clksw_sched
  import clksw_pkg::*;
#(
  parameter int DEAD_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             hsclk,
  input  logic             resetb,
  input  logic             lsclk_in,
  input  logic             hs_req,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
  output logic             cpu_ck_phi2,
  output logic             hs_selected,
  output logic             ls_selected,
  output logic             switching
);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);
  state_t              r_state, w_nxt;
  logic                r_ck, w_ck, r_abort, w_abort, r_hs, r_ls, r_sw;
  logic [DEAD_W-1:0]   r_dead, w_dead;
  logic [PH_W-1:0]     r_phase, w_phase;
  logic [DIV_W-1:0]    r_div, w_div;
  logic                w_ls_s, w_rise, w_fall;
  clksw_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .hsclk  (hsclk),
    .resetb (resetb),
    .i_d    (lsclk_in),
    .o_s    (w_ls_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );
  // next-state and clock decisions; every switch passes through a stop state with the clock low
  always_comb begin
    w_nxt   = r_state;
    w_ck    = r_ck;
    w_dead  = r_dead;
    w_phase = r_phase;
    w_div   = r_div;
    w_abort = r_abort;
    case (r_state)
      LS_RUN: begin
        w_ck = w_ls_s;
        if (hs_req && w_fall) begin
          w_nxt   = LS_STOP;
          w_dead  = DEAD_LOAD;
          w_abort = 1'b0;
        end
      end
      LS_STOP: begin
        w_ck    = 1'b0;
        w_dead  = (r_dead == '0) ? r_dead : r_dead - 1'b1;
        w_abort = r_abort | ~hs_req;
        if (w_abort) begin
          if (w_rise) begin
            w_nxt = LS_RUN;
            w_ck  = 1'b1;
          end
        end else if (r_dead == '0) begin
          w_nxt   = HS_RUN;
          w_phase = '0;
          w_div   = cpuclk_div_sel;
        end
      end
      HS_RUN: begin
        if (r_phase == phase_last(r_div)) begin
          w_phase = '0;
          w_ck    = ~r_ck;
          if (!r_ck) w_div = cpuclk_div_sel;
          else if (!hs_req) begin
            w_nxt  = HS_STOP;
            w_dead = DEAD_LOAD;
          end
        end else w_phase = r_phase + 1'b1;
      end
      HS_STOP: begin
        w_ck = 1'b0;
        if (r_dead != '0) w_dead = r_dead - 1'b1;
        else if (w_rise) begin
          w_nxt = LS_RUN;
          w_ck  = 1'b1;
        end
      end
      default: w_nxt = LS_RUN;
    endcase
  end
  // register state, clock and status together so the status always matches the state
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= LS_RUN;
      r_ck    <= 1'b0;
      r_dead  <= '0;
      r_phase <= '0;
      r_div   <= '0;
      r_abort <= 1'b0;
      r_hs    <= 1'b0;
      r_ls    <= 1'b1;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ck    <= w_ck;
      r_dead  <= w_dead;
      r_phase <= w_phase;
      r_div   <= w_div;
      r_abort <= w_abort;
      r_hs    <= (w_nxt == HS_RUN);
      r_ls    <= (w_nxt == LS_RUN);
      r_sw    <= (w_nxt == LS_STOP) || (w_nxt == HS_STOP);
    end
  end
  assign cpu_ck_phi2 = r_ck;
  assign hs_selected = r_hs;
  assign ls_selected = r_ls;
  assign switching   = r_sw;
endmodule

// File: tb/tb_clksw_sched.sv
// tb_clksw_sched: randomized scoreboard bench for the clock-switch scheduler
module tb_clksw_sched;
  localparam int DEAD = 2;
  localparam int SYNC = 2;
  logic       hsclk = 1'b0, resetb = 1'b0, lsclk_in = 1'b0, hs_req = 1'b0;
  logic [1:0] cpuclk_div_sel = 2'd0;
  logic       cpu_ck_phi2, hs_selected, ls_selected, switching;
  int         errors = 0, checks = 0;
  logic [3:0] exp_q[$];
  typedef enum {M_LS, M_TO_HS, M_HS, M_TO_LS} mode_t;
  mode_t      mode;
  logic       m_ck;
  logic [3:0] hist;
  bit         aborted;
  int         waited, phase_left, len, ls_left;
  clksw_sched #(.DEAD_CYCLES(DEAD), .SYNC_STAGES(SYNC)) dut (
    .hsclk          (hsclk),
    .resetb         (resetb),
    .lsclk_in       (lsclk_in),
    .hs_req         (hs_req),
    .cpuclk_div_sel (cpuclk_div_sel),
    .cpu_ck_phi2    (cpu_ck_phi2),
    .hs_selected    (hs_selected),
    .ls_selected    (ls_selected),
    .switching      (switching)
  );
  always #5 hsclk = ~hsclk;
  // monitor: each cycle the DUT presents its outputs, compare against the oldest expectation
  always @(negedge hsclk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({cpu_ck_phi2, hs_selected, ls_selected, switching} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t {ck,hs,ls,sw} got=%b want=%b", $time,
                 {cpu_ck_phi2, hs_selected, ls_selected, switching}, e);
      end
    end
  end
  task automatic model_reset();
    mode = M_LS; m_ck = 1'b0; hist = 4'b0; aborted = 0; waited = 0; phase_left = 1; len = 1;
  endtask
  task automatic ls_gen();
    ls_left--;
    if (ls_left == 0) begin
      lsclk_in = ~lsclk_in;
      ls_left = $urandom_range(6, 10);
    end
  endtask
  function automatic logic [3:0] model_out();
    return {m_ck, mode == M_HS, mode == M_LS, mode == M_TO_HS || mode == M_TO_LS};
  endfunction
  // behavioural model of one hsclk edge: BBC clock seen SYNC+1 cycles late, counted stop and phase lengths
  task automatic model_step(input logic h, input logic [1:0] sel);
    logic s, rise, fall;
    hist = {hist[2:0], lsclk_in};
    s    = hist[2];
    rise = hist[2] & ~hist[3];
    fall = ~hist[2] & hist[3];
    case (mode)
      M_LS: begin
        m_ck = s;
        if (h && fall) begin mode = M_TO_HS; waited = 0; aborted = 0; end
      end
      M_TO_HS: begin
        m_ck = 1'b0; waited++; aborted = aborted | !h;
        if (aborted) begin
          if (rise) begin mode = M_LS; m_ck = 1'b1; end
        end else if (waited >= DEAD) begin
          mode = M_HS; len = 1 << sel; phase_left = len;
        end
      end
      M_HS: begin
        phase_left--;
        if (phase_left == 0) begin
          m_ck = !m_ck;
          if (m_ck) len = 1 << sel;
          else if (!h) begin mode = M_TO_LS; waited = 0; end
          phase_left = len;
        end
      end
      M_TO_LS: begin
        m_ck = 1'b0; waited++;
        if (waited >= DEAD && rise) begin mode = M_LS; m_ck = 1'b1; end
      end
    endcase
  endtask
  task automatic tick(input logic h, input logic [1:0] sel);
    @(negedge hsclk);
    #1;
    resetb = 1'b1;
    hs_req = h;
    cpuclk_div_sel = sel;
    ls_gen();
    model_step(h, sel);
    exp_q.push_back(model_out());
  endtask
  task automatic rst_tick();
    @(negedge hsclk);
    #1;
    ls_gen();
    model_reset();
    exp_q.push_back(model_out());
  endtask
  task automatic timeout(input string what);
    errors++;
    $display("FAIL wait_%s got=timeout want=reached", what);
  endtask
  initial begin
    logic h;
    logic [1:0] sel;
    int n;
    ls_left = 8;
    model_reset();
    repeat (2) @(negedge hsclk);
    checks++;
    if ({cpu_ck_phi2, hs_selected, ls_selected, switching} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_state got=%b want=0010", {cpu_ck_phi2, hs_selected, ls_selected, switching});
    end
    repeat (100) tick(1'b0, 2'd0);
    repeat (100) tick(1'b1, 2'd0);
    n = 0;
    while (!(mode == M_HS && m_ck && phase_left == 2) && n < 300) begin tick(1'b1, 2'd2); n++; end
    if (n == 300) timeout("hs_high_div2");
    repeat (100) tick(1'b0, 2'd2);
    n = 0;
    while (!(mode == M_HS && m_ck) && n < 300) begin tick(1'b1, 2'd0); n++; end
    if (n == 300) timeout("hs_high_div0");
    repeat (80) tick(1'b1, 2'd3);
    n = 0;
    while (mode != M_LS && n < 300) begin tick(1'b0, 2'd0); n++; end
    if (n == 300) timeout("ls_run");
    n = 0;
    while (!(hist[1] == 1'b0 && hist[2] == 1'b1) && n < 300) begin tick(1'b0, 2'd0); n++; end
    if (n == 300) timeout("fall");
    tick(1'b1, 2'd0);
    repeat (60) tick(1'b0, 2'd0);
    n = 0;
    while (!(mode == M_HS && m_ck) && n < 300) begin tick(1'b1, 2'd1); n++; end
    if (n == 300) timeout("hs_high_reset");
    @(negedge hsclk);
    #1;
    resetb = 1'b0;
    #1;
    checks++;
    if ({cpu_ck_phi2, hs_selected, ls_selected, switching} !== 4'b0010) begin
      errors++;
      $display("FAIL async_reset got=%b want=0010", {cpu_ck_phi2, hs_selected, ls_selected, switching});
    end
    ls_gen();
    model_reset();
    exp_q.push_back(model_out());
    repeat (2) rst_tick();
    repeat (60) tick(1'b0, 2'd0);
    h = 1'b0;
    sel = 2'd0;
    n = 0;
    repeat (3000) begin
      if (n == 0) begin
        h = ~h;
        n = $urandom_range(1, 60);
      end
      n--;
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      tick(h, sel);
    end
    @(negedge hsclk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
